// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word size,
// fault classification and wait-counter width.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;
  localparam logic [1:0] FAULT_CONFLICT = 2'd3;

  // Conflicting strobes dominate; a misaligned address is reported before range.
  function automatic logic [1:0] fault_code(input logic        rd,
                                            input logic        wr,
                                            input logic [31:0] addr,
                                            input int unsigned depth);
    if (rd && wr)
      return FAULT_CONFLICT;
    if (addr[1:0] != 2'b00)
      return FAULT_MISALIGN;
    if ({2'b00, addr[31:2]} >= depth)
      return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface data_mem_resp_if;

  logic        memread;
  logic        memwrite;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        error;

  modport master (
    output memread, memwrite, address, writedata,
    input  readdata, ready, error
  );

  modport slave (
    input  memread, memwrite, address, writedata,
    output readdata, ready, error
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port 32-bit word storage; the read register doubles as the held load result.
module dmem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we)
      mem[idx] <= wdata;
  end

  // Only a successful load updates rdata, so it holds between loads.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (re)
      rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: latches a load/store, waits WAIT_STATES cycles, then
// commits it and pulses ready (with error on a faulted access).
module data_mem_resp
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic          clock,
  input  logic          Reset,
  data_mem_resp_if.slave bus
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int IDX_LSB = $clog2(WORD_BYTES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_rd;
  logic             lat_wr;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic             ready_q;
  logic             error_q;

  logic             cur_rd;
  logic             cur_wr;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic             req_live;
  logic             go_resp;
  logic             fault;
  logic             mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;

  // With zero wait states the commit edge is the accept edge, so use the live bus.
  always_comb begin
    cur_rd    = lat_rd;
    cur_wr    = lat_wr;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_rd    = bus.memread;
      cur_wr    = bus.memwrite;
      cur_addr  = bus.address;
      cur_wdata = bus.writedata;
    end
  end

  assign req_live = bus.memread | bus.memwrite;
  assign fault    = (fault_code(cur_rd, cur_wr, cur_addr, DEPTH_WORDS) != FAULT_NONE);

  always_comb begin
    go_resp = 1'b0;
    case (state)
      IDLE:    go_resp = req_live && (WAIT_STATES == 0);
      WAIT:    go_resp = req_live && (cnt == CNT_W'(1));
      default: go_resp = 1'b0;
    endcase
    go_resp = go_resp && Reset;
  end

  assign mem_we = go_resp && !fault && cur_wr;
  assign mem_re = go_resp && !fault && cur_rd;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      ready_q <= go_resp;
      error_q <= go_resp && fault;
      case (state)
        IDLE: begin
          if (req_live) begin
            lat_rd    <= bus.memread;
            lat_wr    <= bus.memwrite;
            lat_addr  <= bus.address;
            lat_wdata <= bus.writedata;
            cnt       <= CNT_W'(WAIT_STATES);
            state     <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!req_live) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock (clock),
    .rst_n (Reset),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (cur_addr[IDX_LSB +: IDX_W]),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  assign bus.readdata = mem_rdata;
  assign bus.ready    = ready_q;
  assign bus.error    = error_q;

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder for the single-cycle core's load/store interface.
- Sits on the memread/memwrite/address/writedata/readdata path that currently has no responder.
- Word-addressed storage with a parameterised wait-state count, so the core can stall on a ready pulse. Flags misaligned, out-of-range and conflicting requests.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; legal byte addresses are 0 .. 4*DEPTH_WORDS-4.
- WAIT_STATES, 2, extra cycles between request acceptance and response (0 allowed, max 15).

Ports:
- clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- memread  input  1  load request; held by the core until ready.
- memwrite  input  1  store request; held by the core until ready.
- address  input  32  byte address (ALU result).
- writedata  input  32  store data (register file read port 2).
- readdata  output  32  load data; valid when ready and memread.
- ready  output  1  one-cycle completion pulse.
- error  output  1  one-cycle pulse coincident with ready on a faulted access.

Behaviour:
- Reset (Reset low, asynchronous) forces the following values:
  - state = IDLE
  - readdata = 0, ready = 0, error = 0
  - wait counter = 0
  - storage contents are not reset.
- States:
  - IDLE
    - A valid request is memread XOR memwrite, or both asserted.
    - On a valid request at an edge: latch address, writedata and operation; load counter = WAIT_STATES.
    - Go to RESP if WAIT_STATES==0, else WAIT.
    - With no request: stay in IDLE, ready=0.
  - WAIT
    - Each edge decrements the counter. When the counter is 1 at the edge, go to RESP.
    - Both request lines low at an edge: abort to IDLE. No write is committed and no ready is issued.
  - RESP
    - ready=1 for exactly this one cycle; next edge returns to IDLE.
    - A request still held in the following IDLE cycle is accepted as a new access (back-to-back).
- Latency: request first sampled at edge E0 → ready high in the cycle after edge E0+WAIT_STATES. WAIT_STATES=2 gives 3 edges and 3 stall cycles seen by the core.
- Faults, checked on the latched request:
  - address[1:0] != 0 → misaligned.
  - word index address[31:2] >= DEPTH_WORDS → out of range.
  - memread and memwrite both high → conflict.
  - Response on a fault: ready=1, error=1, no store committed, readdata unchanged.
- Store: storage[address[31:2]] <= latched writedata on the edge entering RESP, only if there is no fault.
- Load: readdata <= storage[word index] on the edge entering RESP. readdata holds its value until the next successful load completes.
- ready and error are registered outputs with no combinational path from the inputs.
- Address and data changing during WAIT while a request line stays high: ignored; the latched values are used.
- Reset asserted mid-access: the access is dropped, no write is committed, and all outputs go to their reset values immediately.

Decomposition:
- Shared package mips_mem_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - WORD_BYTES=4
  - fault code localparams
  - counter width constant (4 bits)
- One natural sub-module: dmem_array, the synchronous single-port 32-bit word storage (write enable, word index, wdata, rdata), so the FSM stays separate from the storage.

Test Plan:
- WAIT_STATES=2: store address 0x10, writedata 0xDEADBEEF, memwrite held → ready pulses 3 edges after acceptance, error=0. Then a load from 0x10 → readdata=0xDEADBEEF with ready.
- Store to misaligned address 0x13 with writedata 0x12345678, then load from 0x10 → first access gives ready=1/error=1. The load returns the prior value; the storage word is unchanged.
- Load from address 0x400 with DEPTH_WORDS=256 (word index 256) → ready=1, error=1, readdata keeps its previous value.
- Store to 0x20 with requests dropped low after 1 WAIT edge → no ready. A later load from 0x20 returns the old contents.
- Back-to-back: store 0x4=0x1, held into IDLE and then changed to a load from 0x4 → two separate ready pulses, with one IDLE cycle between them. The second returns 0x00000001.
- WAIT_STATES=0, plus a reset pulse mid-WAIT with WAIT_STATES=2 → ready the cycle after acceptance. Reset gives immediate readdata=0, ready=0 and no commit; memread+memwrite together → error=1.
